// File: rtl/uart_tx_stream_if.sv
// Byte-stream handshake between a producer and the UART transmitter.
// The producer drives tx_data/tx_valid; the transmitter answers with tx_ready.
interface uart_tx_stream_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_stream.sv
// Byte-stream UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity, 1 or 2 stop bits. A one-entry holding register lets the
// producer queue the next byte so frames leave back-to-back.
module uart_tx_stream #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_stream_if.slave stream,
  output logic            tx,
  output logic            busy
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [BW-1:0]        baud_q;
  logic [CW-1:0]        bit_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 baud_last;

  // Ready is the registered empty flag, so no input reaches tx_ready combinationally.
  assign stream.tx_ready = ~hold_full_q;
  assign baud_last       = (baud_q == BAUD_LAST);
  assign tx              = tx_q;
  assign busy            = busy_q;

  // Holding register, frame sequencer and registered line/busy outputs.
  // tx_q follows the state one cycle late, so each bit still lasts CLKS_PER_BIT
  // cycles on the line and the start bit appears two edges after the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      baud_q      <= '0;
      bit_q       <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      // Accept only while empty; a transfer out never coincides with this.
      if (stream.tx_valid && !hold_full_q) begin
        hold_q      <= stream.tx_data;
        hold_full_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (hold_full_q) begin
            shift_q     <= hold_q;
            parity_q    <= (^hold_q) ^ PAR_INV;
            hold_full_q <= 1'b0;
            baud_q      <= '0;
            bit_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= StStart;
          end
        end

        StStart: begin
          tx_q <= 1'b0;
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        StData: begin
          tx_q <= shift_q[0];
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
              state_q <= (PARITY_EN != 0) ? StParity : StStop;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        StParity: begin
          tx_q <= parity_q;
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        StStop: begin
          tx_q <= 1'b1;
          if (baud_last) begin
            baud_q <= '0;
            // bit_q counts stop bits here
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (hold_full_q) begin
                // Chain straight into the next frame with no idle gap.
                shift_q     <= hold_q;
                parity_q    <= (^hold_q) ^ PAR_INV;
                hold_full_q <= 1'b0;
                state_q     <= StStart;
              end else begin
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at CLKS_PER_BIT = 4 across four framings:
// 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 7N2. Inputs change and outputs are sampled
// on the falling edge.
module tb_uart_tx_stream;

  logic       clk;
  logic       reset;
  logic [7:0] dat [4];
  logic [3:0] vld;
  logic [3:0] rdy;
  logic [3:0] txl;
  logic [3:0] bsy;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_stream_if #(.DATA_BITS(8)) if0 ();
  uart_tx_stream_if #(.DATA_BITS(8)) if1 ();
  uart_tx_stream_if #(.DATA_BITS(8)) if2 ();
  uart_tx_stream_if #(.DATA_BITS(7)) if3 ();

  assign if0.tx_data  = dat[0];
  assign if1.tx_data  = dat[1];
  assign if2.tx_data  = dat[2];
  assign if3.tx_data  = dat[3][6:0];
  assign if0.tx_valid = vld[0];
  assign if1.tx_valid = vld[1];
  assign if2.tx_valid = vld[2];
  assign if3.tx_valid = vld[3];
  assign rdy[0]       = if0.tx_ready;
  assign rdy[1]       = if1.tx_ready;
  assign rdy[2]       = if2.tx_ready;
  assign rdy[3]       = if3.tx_ready;

  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .stream(if0), .tx(txl[0]), .busy(bsy[0]));
  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .stream(if1), .tx(txl[1]), .busy(bsy[1]));
  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .stream(if2), .tx(txl[2]), .busy(bsy[2]));
  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .stream(if3), .tx(txl[3]), .busy(bsy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bits in line order: bit 0 is the start bit.
  typedef struct {
    int         k;
    logic [7:0] data;
    logic [11:0] frame;
    int         nbits;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Single frame from idle: latency, every bit for all four cycles, busy length.
  task automatic send_frame(input int k, input logic [7:0] d, input logic [11:0] f,
                            input int nb, input string nm);
    logic [3:0] seg;
    int bz;
    @(negedge clk);
    check($sformatf("%s rdy_pre", nm), 128'(rdy[k]), 128'd1);
    dat[k] = d;
    vld[k] = 1'b1;
    @(negedge clk);
    vld[k] = 1'b0;
    check($sformatf("%s lat0 tx/busy/rdy", nm), {txl[k], bsy[k], rdy[k]}, 3'b100);
    @(negedge clk);
    check($sformatf("%s lat1 tx/busy/rdy", nm), {txl[k], bsy[k], rdy[k]}, 3'b111);
    bz = int'(bsy[k]);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        seg[c] = txl[k];
        bz += int'(bsy[k]);
      end
      check($sformatf("%s bit%0d", nm, b), seg, {4{f[b]}});
    end
    @(negedge clk);
    check($sformatf("%s end tx/busy/rdy", nm), {txl[k], bsy[k], rdy[k]}, 3'b101);
    check($sformatf("%s busy_cycles", nm), bz, 4 * nb);
  endtask

  // Two frames with tx_valid held until the second byte is taken.
  task automatic b2b(input int k, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [11:0] f0, input logic [11:0] f1, input int nb,
                     input string nm);
    logic [127:0] tx_s, bz_s, rd_s, tx_e, bz_e;
    int len, b;
    len  = 4 * nb;
    tx_s = '0; bz_s = '0; rd_s = '0; tx_e = '0; bz_e = '0;
    @(negedge clk);
    dat[k] = d0;
    vld[k] = 1'b1;
    for (int j = 0; j < 2 * len + 6; j++) begin
      @(negedge clk);
      tx_s[j] = txl[k];
      bz_s[j] = bsy[k];
      rd_s[j] = rdy[k];
      if (j == 0) dat[k] = d1;
      if (j == 2) vld[k] = 1'b0;
      b = (j - 2) / 4;
      if (j >= 2 && b < nb)          tx_e[j] = f0[b];
      else if (j >= 2 && b < 2 * nb) tx_e[j] = f1[b - nb];
      else                           tx_e[j] = 1'b1;
      bz_e[j] = (j >= 1 && j <= 2 * len);
    end
    check($sformatf("%s tx", nm), tx_s, tx_e);
    check($sformatf("%s busy", nm), bz_s, bz_e);
    check($sformatf("%s rdy", nm), {rd_s[1], rd_s[2], rd_s[len], rd_s[len+1]}, 4'b1001);
  endtask

  initial begin
    logic [23:0] idle_s;
    reset = 1'b1;
    vld   = '0;
    for (int i = 0; i < 4; i++) dat[i] = '0;

    vecs[0]  = '{0, 8'hA5, 12'b00_1_10100101_0, 10};
    vecs[1]  = '{0, 8'h00, 12'b00_1_00000000_0, 10};
    vecs[2]  = '{0, 8'hFF, 12'b00_1_11111111_0, 10};
    vecs[3]  = '{0, 8'h3C, 12'b00_1_00111100_0, 10};
    vecs[4]  = '{1, 8'h07, 12'b0_1_1_00000111_0, 11};
    vecs[5]  = '{1, 8'h03, 12'b0_1_0_00000011_0, 11};
    vecs[6]  = '{2, 8'h07, 12'b0_1_0_00000111_0, 11};
    vecs[7]  = '{2, 8'h03, 12'b0_1_1_00000011_0, 11};
    vecs[8]  = '{3, 8'h55, 12'b00_11_1010101_0, 10};
    vecs[9]  = '{3, 8'h2A, 12'b00_11_0101010_0, 10};
    vecs[10] = '{1, 8'h00, 12'b0_1_0_00000000_0, 11};
    vecs[11] = '{2, 8'h00, 12'b0_1_1_00000000_0, 11};

    repeat (3) @(negedge clk);
    check("in_reset tx/rdy/busy", {txl, rdy, bsy}, 12'hFF0);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d tx/rdy/busy", i), {txl, rdy, bsy}, 12'hFF0);
    end

    for (int i = 0; i < 12; i++)
      send_frame(vecs[i].k, vecs[i].data, vecs[i].frame, vecs[i].nbits, $sformatf("v%0d", i));

    b2b(0, 8'h00, 8'hFF, 12'b00_1_00000000_0, 12'b00_1_11111111_0, 10, "b2b_8n1");
    b2b(3, 8'h55, 8'h2A, 12'b00_11_1010101_0, 12'b00_11_0101010_0, 10, "b2b_7n2");

    // Reset during a start bit takes effect without a clock edge.
    @(negedge clk);
    dat[0] = 8'hA5;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("r1 start_bit tx", 128'(txl[0]), 128'd0);
    reset = 1'b1;
    #1;
    check("r1 async tx/rdy/busy", {txl[0], rdy[0], bsy[0]}, 3'b110);
    @(negedge clk);
    reset = 1'b0;

    // Reset during data bit 3 of 0x3C with 0x99 queued: queued byte is lost.
    @(negedge clk);
    dat[0] = 8'h3C;
    vld[0] = 1'b1;
    @(negedge clk);
    dat[0] = 8'h99;
    @(negedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    check("r2 queued rdy", 128'(rdy[0]), 128'd0);
    repeat (17) @(negedge clk);
    check("r2 pre busy/rdy", {bsy[0], rdy[0]}, 2'b10);
    reset = 1'b1;
    #1;
    check("r2 async tx/rdy/busy", {txl[0], rdy[0], bsy[0]}, 3'b110);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_s = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle_s[2*i]   = txl[0];
      idle_s[2*i+1] = bsy[0];
    end
    check("r2 dropped byte stays off line", idle_s, 24'h555555);
    send_frame(0, 8'h5A, 12'b00_1_01011010_0, 10, "r2_new");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Byte-stream UART transmitter with a valid/ready input handshake. It serialises bytes supplied by an upstream producer onto a single serial line that the team's UART receiver can consume. Framing is configurable: data width, optional even/odd parity, 1 or 2 stop bits. A one-entry holding register lets the producer queue the next byte while the current frame is on the line, so consecutive frames go out back-to-back.

Parameters:
CLKS_PER_BIT, 10416, clk cycles per serial bit (100 MHz / 9600 baud); legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY_EN, 0, 1 = append a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  single system clock, rising-edge
reset  input  1  asynchronous, active-high reset
tx_data  input  DATA_BITS  byte to send; sampled only on handshake
tx_valid  input  1  producer has a byte on tx_data
tx_ready  output  1  holding register empty; byte accepted when tx_valid && tx_ready at a rising edge
tx  output  1  serial line; idles high
busy  output  1  high while any frame bit is being driven

Behaviour:
- Reset: tx = 1, tx_ready = 1, busy = 0. The FSM goes to IDLE and the holding register, shift register, baud counter and bit counter all clear. Reset takes effect immediately, including mid-frame.
- tx_ready = !hold_full, decoded combinationally from the registered flag.
- Handshake: on an edge with tx_valid && tx_ready, tx_data is loaded into the holding register and hold_full is set. tx_data is ignored when tx_ready = 0.
- FSM states and transitions:
  - IDLE: tx = 1, busy = 0. If hold_full, move the holding register into the shift register, clear hold_full and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive shift[0], LSB first, for CLKS_PER_BIT cycles per bit, then shift right. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: drive XOR of the frame's data bits, inverted when PARITY_ODD, for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle: if hold_full, transfer the holding register to the shift register, clear hold_full and go straight to START (no idle gap); else go to IDLE.
- Latency: a byte accepted at edge N while in IDLE gives tx = 0 from edge N+2 (N+1 loads the shift register and enters START).
- Timing: every bit lasts exactly CLKS_PER_BIT cycles. Frame length is (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- busy is high from entry into START until the exit from STOP to IDLE. It stays high continuously across back-to-back frames.
- Counters: the baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is clog2(CLKS_PER_BIT). The bit counter width is clog2(DATA_BITS+1).
- tx is driven from a register (glitch-free); there are no combinational paths from inputs to tx.
- Producer protocol: tx_data and tx_valid must stay stable while tx_valid = 1 and tx_ready = 0. Dropping tx_valid without a handshake is allowed and has no effect.
- Simultaneous events: a transfer out of the holding register and a new handshake cannot occur on the same edge, because tx_ready = 0 while hold_full. A new byte is accepted on the first edge after the holding register empties.

Test Plan:
1. Reset, then idle for 20 cycles -> tx = 1, tx_ready = 1, busy = 0 throughout; assert reset during a frame -> tx = 1 and tx_ready = 1 immediately, with no clock needed.
2. CLKS_PER_BIT = 4, 8N1, send 0xA5 -> tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; busy high for exactly 40 cycles; start bit begins 2 edges after the handshake.
3. Back-to-back: 0x00, then 0xFF with tx_valid held high -> 0xFF accepted during the first frame; tx_ready low until the first frame's final stop cycle; 0xFF start bit immediately follows the stop bit; busy high for 80 continuous cycles.
4. PARITY_EN = 1, PARITY_ODD = 0: 0x07 -> parity bit 1, 0x03 -> parity bit 0. PARITY_ODD = 1: 0x07 -> 0. Frame length is 44 cycles at CLKS_PER_BIT = 4.
5. STOP_BITS = 2, DATA_BITS = 7, send 0x55 then 0x2A -> line high for 8 cycles between data end and next start; 7 data bits per frame; frame length 40 cycles.
6. Reset asserted during data bit 3 of 0x3C with a second byte queued -> holding register dropped; after release only newly supplied bytes are sent, beginning with a clean start bit; the dropped byte never appears on tx.
